// File: rtl/stack_unit.sv
// LIFO stack for the pipelined core. Pops read the top entry combinationally
// and pushes become visible one cycle later. Sticky overflow/underflow flags aid debug.
`timescale 1ns/1ps
module stack_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pushEn,
  input  logic             popEn,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data_out,
  output logic             stackFull,
  output logic             stackEmpty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } op_e;

  logic [CW-1:0]    sp_q, sp_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             full, empty;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  op_e              op;

  assign full    = (sp_q == DEPTH_C);
  assign empty   = (sp_q == '0);
  assign top_idx = AW'(sp_q - ONE_C);
  assign op      = op_e'({pushEn, popEn});

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    sp_d        = sp_q;
    overflow_d  = clr_err ? 1'b0 : overflow_q;
    underflow_d = clr_err ? 1'b0 : underflow_q;
    wr_en       = 1'b0;
    wr_idx      = AW'(sp_q);

    unique case (op)
      OP_PUSH: begin
        if (full) begin
          overflow_d = 1'b1;
        end else begin
          wr_en = 1'b1;
          sp_d  = sp_q + ONE_C;
        end
      end
      OP_POP: begin
        if (empty) underflow_d = 1'b1;
        else       sp_d        = sp_q - ONE_C;
      end
      OP_REPLACE: begin
        wr_en = 1'b1;
        if (empty) begin
          // The pop is refused, but the push still lands in slot 0.
          underflow_d = 1'b1;
          wr_idx      = '0;
          sp_d        = ONE_C;
        end else begin
          wr_idx = top_idx;
        end
      end
      default: ;
    endcase

    // Edges sampled while reset is high are discarded.
    if (reset) wr_en = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array has no reset. Entries at or above sp are never
  // observed, so clearing them would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= data_in;
  end

  assign data_out   = empty ? '0 : mem_q[top_idx];
  assign stackFull  = full;
  assign stackEmpty = empty;
  assign count      = sp_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

  sp_in_range: assert property (@(posedge clk) disable iff (reset) sp_q <= DEPTH_C);

endmodule
